out_sampler: RTL and testbench
==============================

OUT_SAMPLER -- requirements
Module: out_sampler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: bit width of the signed fixed-point sample.
REQ-002 The block SHALL have parameter DEPTH, default 8: FIFO entries, power of two, 2..256.
REQ-003 The block SHALL have parameter DECIM, default 4: capture period in clocks, 1..65535.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: capture enable.
REQ-007 The block SHALL have port in_, input, WIDTH bits: the model's fixed-point output, signed, sampled directly.
REQ-008 The block SHALL have port out, output, WIDTH bits: the head-of-FIFO sample.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out holds a valid sample.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky; set when a capture was dropped.

Function
REQ-013 A decimation counter SHALL run 0..DECIM-1 while en=1, wrapping to 0, and SHALL hold its value while en=0.
REQ-014 A capture SHALL occur on the edge where en=1 and the counter equals DECIM-1; with DECIM=1, a capture SHALL occur on every en=1 edge.
REQ-015 A capture SHALL write in_ as sampled at that edge into the FIFO tail, and out_valid SHALL rise one clock later if the FIFO was empty.
REQ-016 A pop SHALL occur on the edge where out_valid=1 and out_ready=1; out SHALL advance to the next entry on the following cycle.
REQ-017 out and out_valid SHALL be driven from registers, with no combinational path from in_ or out_ready to any output.
REQ-018 out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 Full FIFO (count=DEPTH) with capture and no pop: the capture SHALL be dropped, overflow SHALL be set, and the stored data SHALL be unchanged.
REQ-020 Full FIFO with capture and pop on the same edge: both SHALL occur, count SHALL stay DEPTH, and overflow SHALL not be set.
REQ-021 Empty FIFO with capture: no same-cycle bypass SHALL occur; latency SHALL be one clock from the capture edge to out_valid.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 overflow SHALL clear only on reset.
REQ-024 Deasserting en SHALL not flush the FIFO; pops SHALL continue.

Reset
REQ-025 While rst=0 at a rising clk edge, the block SHALL set count=0, out_valid=0, out=0, overflow=0, pointers=0 and decimation counter=0.
REQ-026 An in-flight capture or pop on a reset edge SHALL be discarded.
REQ-027 The first possible capture after reset release SHALL be on the DECIM-th en=1 edge.
REQ-028 FIFO storage contents SHALL NOT require reset.

Configuration
REQ-029 When macro OUT_SAMPLER_MINMAX_EN is defined, the block SHALL add outputs min_val and max_val (WIDTH bits, signed).
REQ-030 min_val and max_val SHALL update on every capture, including dropped captures.
REQ-031 min_val and max_val SHALL reset to the most-positive and most-negative values respectively, and the first capture SHALL load both.
REQ-032 When OUT_SAMPLER_MINMAX_EN is undefined, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL check: DECIM=4, en=1, in_ ramps 0,1,2,... per clock, out_ready=1 -> out_valid pulses every 4 clocks with out = 3, 7, 11, ....
REQ-034 The bench SHALL check: DECIM=1, DEPTH=8, out_ready=0 for 10 en clocks -> count=8, overflow=1 after the 9th capture, and pops return the first 8 in_ values in order.
REQ-035 The bench SHALL check: full FIFO, out_ready=1 and capture on the same edge -> count stays 8, overflow stays 0, and the new sample appears after 7 pops.
REQ-036 The bench SHALL check: en toggles 1,0,1 mid-period with DECIM=4 -> the capture is delayed exactly by the number of en=0 cycles.
REQ-037 The bench SHALL check: rst=0 for one edge with count=5 -> count=0, out_valid=0 and overflow=0 next cycle, and the first capture occurs DECIM en-edges later.
REQ-038 The bench SHALL check, with OUT_SAMPLER_MINMAX_EN defined: captures -5, 12, -30, 7 -> min_val=-30 and max_val=12.

Source files
------------

// File: rtl/out_sampler.sv
// Decimating sampler: captures in_ every DECIM enabled clocks into a FIFO.
// Define OUT_SAMPLER_MINMAX_EN to add running min_val / max_val outputs.
module out_sampler #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int DECIM = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [WIDTH-1:0]        in_,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
`ifdef OUT_SAMPLER_MINMAX_EN
    ,
    output logic signed [WIDTH-1:0] min_val,
    output logic signed [WIDTH-1:0] max_val
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] DLAST = 16'(DECIM - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [15:0]      dcnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [AW:0]      cnt_nxt;
    logic [AW:0]      cnt_after_pop;
    logic [WIDTH-1:0] head_nxt;
    logic             capture;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    always_comb begin
        capture       = en && (dcnt == DLAST);
        full          = (count == FULL);
        pop           = out_valid && out_ready;
        push          = capture && (!full || pop);
        drop          = capture && full && !pop;
        rd_nxt        = pop ? rd_ptr + AW'(1) : rd_ptr;
        cnt_after_pop = count - (AW + 1)'(pop);
        cnt_nxt       = cnt_after_pop + (AW + 1)'(push);
        // The output register is preloaded with the next head; when the
        // FIFO drains to empty the incoming sample becomes the new head.
        head_nxt      = (push && cnt_after_pop == '0) ? in_ : mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= in_;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dcnt      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (en) begin
                dcnt <= capture ? '0 : dcnt + 16'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_nxt;
            count     <= cnt_nxt;
            out_valid <= (cnt_nxt != '0);
            if (cnt_nxt != '0) begin
                out <= head_nxt;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef OUT_SAMPLER_MINMAX_EN
    // Tracks every capture, including ones dropped on a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            min_val <= {1'b0, {(WIDTH - 1){1'b1}}};
            max_val <= {1'b1, {(WIDTH - 1){1'b0}}};
        end else if (capture) begin
            if ($signed(in_) < min_val) begin
                min_val <= in_;
            end
            if ($signed(in_) > max_val) begin
                max_val <= in_;
            end
        end
    end
`endif

endmodule

// File: tb/tb_out_sampler.sv
// Directed bench for out_sampler: one DECIM=4 and one DECIM=1 instance.
module tb_out_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rst4 = 1'b0, en4 = 1'b0, rdy4 = 1'b0;
    logic [15:0] in4 = '0;
    logic [15:0] out4;
    logic        out_valid4, overflow4;
    logic [3:0]  count4;

    logic        rst1 = 1'b0, en1 = 1'b0, rdy1 = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] out1;
    logic        out_valid1, overflow1;
    logic [3:0]  count1;

`ifdef OUT_SAMPLER_MINMAX_EN
    logic signed [15:0] min4, max4, min1, max1;
`endif

    out_sampler #(.WIDTH(16), .DEPTH(8), .DECIM(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .in_(in4),
        .out(out4), .out_valid(out_valid4), .out_ready(rdy4),
        .count(count4), .overflow(overflow4)
`ifdef OUT_SAMPLER_MINMAX_EN
        , .min_val(min4), .max_val(max4)
`endif
    );

    out_sampler #(.WIDTH(16), .DEPTH(8), .DECIM(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .in_(in1),
        .out(out1), .out_valid(out_valid1), .out_ready(rdy1),
        .count(count1), .overflow(overflow1)
`ifdef OUT_SAMPLER_MINMAX_EN
        , .min_val(min1), .max_val(max1)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst4 = 1'b0;
        rst1 = 1'b0;
        tick();
        n_checks++; if (count4 !== 4'd0) begin n_fail++; $display("FAIL reset_count4 got=%0d exp=0", count4); end
        n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid4 got=%b exp=0", out_valid4); end
        n_checks++; if (overflow4 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf4 got=%b exp=0", overflow4); end
        n_checks++; if (out4 !== 16'd0) begin n_fail++; $display("FAIL reset_out4 got=%0d exp=0", out4); end
        n_checks++; if (count1 !== 4'd0) begin n_fail++; $display("FAIL reset_count1 got=%0d exp=0", count1); end
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid1 got=%b exp=0", out_valid1); end
        rst4 = 1'b1;
        rst1 = 1'b1;
    endtask

    task automatic test_decim;
        logic exp_v;
        en4  = 1'b1;
        rdy4 = 1'b1;
        for (int e = 0; e < 16; e++) begin
            in4 = 16'(e);
            tick();
            exp_v = (e % 4 == 3);
            n_checks++; if (out_valid4 !== exp_v) begin n_fail++; $display("FAIL decim_valid e=%0d got=%b exp=%b", e, out_valid4, exp_v); end
            if (exp_v) begin
                n_checks++; if (out4 !== 16'(e)) begin n_fail++; $display("FAIL decim_out e=%0d got=%0d exp=%0d", e, out4, e); end
            end
        end
        en4 = 1'b0;
    endtask

    task automatic test_en_toggle;
        logic [7:0] en_pat;
        logic       exp_v;
        en_pat = 8'b1110_0011;
        rst4 = 1'b0;
        tick();
        rst4 = 1'b1;
        rdy4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en4 = en_pat[i];
            in4 = 16'(100 + i);
            tick();
            exp_v = (i == 6);
            n_checks++; if (out_valid4 !== exp_v) begin n_fail++; $display("FAIL entoggle_valid i=%0d got=%b exp=%b", i, out_valid4, exp_v); end
            if (exp_v) begin
                n_checks++; if (out4 !== 16'd106) begin n_fail++; $display("FAIL entoggle_out got=%0d exp=106", out4); end
            end
        end
        en4 = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp_c;
        rst4 = 1'b0;
        tick();
        rst4 = 1'b1;
        rdy4 = 1'b0;
        en4  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in4 = 16'(200 + i);
            tick();
        end
        n_checks++; if (count4 !== 4'd5) begin n_fail++; $display("FAIL rstmid_pre_count got=%0d exp=5", count4); end
        rst4 = 1'b0;
        tick();
        rst4 = 1'b1;
        n_checks++; if (count4 !== 4'd0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", count4); end
        n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", out_valid4); end
        n_checks++; if (overflow4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got=%b exp=0", overflow4); end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_c = (i == 3) ? 4'd1 : 4'd0;
            n_checks++; if (count4 !== exp_c) begin n_fail++; $display("FAIL rstmid_first_cap i=%0d got=%0d exp=%0d", i, count4, exp_c); end
        end
        en4 = 1'b0;
    endtask

    task automatic test_overflow;
        logic [3:0] exp_c;
        logic       exp_o;
        rst1 = 1'b0;
        tick();
        rst1 = 1'b1;
        rdy1 = 1'b0;
        en1  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in1 = 16'(10 + i);
            tick();
            exp_c = (i < 8) ? 4'(i + 1) : 4'd8;
            exp_o = (i >= 8);
            n_checks++; if (count1 !== exp_c) begin n_fail++; $display("FAIL ovf_count i=%0d got=%0d exp=%0d", i, count1, exp_c); end
            n_checks++; if (overflow1 !== exp_o) begin n_fail++; $display("FAIL ovf_flag i=%0d got=%b exp=%b", i, overflow1, exp_o); end
        end
        en1 = 1'b0;
        tick();
        n_checks++; if (out1 !== 16'd10) begin n_fail++; $display("FAIL ovf_stall_out got=%0d exp=10", out1); end
        rdy1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL ovf_pop_valid k=%0d got=%b exp=1", k, out_valid1); end
            n_checks++; if (out1 !== 16'(10 + k)) begin n_fail++; $display("FAIL ovf_pop_out k=%0d got=%0d exp=%0d", k, out1, 10 + k); end
            tick();
        end
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got=%b exp=0", out_valid1); end
        n_checks++; if (overflow1 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow1); end
        rdy1 = 1'b0;
    endtask

    task automatic test_full_same_edge;
        rst1 = 1'b0;
        tick();
        rst1 = 1'b1;
        rdy1 = 1'b0;
        en1  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in1 = 16'(20 + i);
            tick();
        end
        n_checks++; if (count1 !== 4'd8) begin n_fail++; $display("FAIL full_pre_count got=%0d exp=8", count1); end
        in1  = 16'd99;
        rdy1 = 1'b1;
        tick();
        en1 = 1'b0;
        n_checks++; if (count1 !== 4'd8) begin n_fail++; $display("FAIL full_same_count got=%0d exp=8", count1); end
        n_checks++; if (overflow1 !== 1'b0) begin n_fail++; $display("FAIL full_same_ovf got=%b exp=0", overflow1); end
        for (int k = 0; k < 7; k++) begin
            n_checks++; if (out1 !== 16'(21 + k)) begin n_fail++; $display("FAIL full_pop_out k=%0d got=%0d exp=%0d", k, out1, 21 + k); end
            tick();
        end
        n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL full_new_valid got=%b exp=1", out_valid1); end
        n_checks++; if (out1 !== 16'd99) begin n_fail++; $display("FAIL full_new_out got=%0d exp=99", out1); end
        tick();
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL full_drained got=%b exp=0", out_valid1); end
        rdy1 = 1'b0;
    endtask

`ifdef OUT_SAMPLER_MINMAX_EN
    task automatic test_minmax;
        logic signed [15:0] vals [4];
        logic signed [15:0] exp_min [4];
        logic signed [15:0] exp_max [4];
        vals    = '{-16'sd5, 16'sd12, -16'sd30, 16'sd7};
        exp_min = '{-16'sd5, -16'sd5, -16'sd30, -16'sd30};
        exp_max = '{-16'sd5, 16'sd12, 16'sd12, 16'sd12};
        rst1 = 1'b0;
        tick();
        rst1 = 1'b1;
        n_checks++; if (min1 !== 16'sh7FFF) begin n_fail++; $display("FAIL minmax_rst_min got=%0d exp=32767", min1); end
        n_checks++; if (max1 !== 16'sh8000) begin n_fail++; $display("FAIL minmax_rst_max got=%0d exp=-32768", max1); end
        rdy1 = 1'b1;
        en1  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1 = vals[i];
            tick();
            n_checks++; if (min1 !== exp_min[i]) begin n_fail++; $display("FAIL minmax_min i=%0d got=%0d exp=%0d", i, min1, exp_min[i]); end
            n_checks++; if (max1 !== exp_max[i]) begin n_fail++; $display("FAIL minmax_max i=%0d got=%0d exp=%0d", i, max1, exp_max[i]); end
        end
        en1  = 1'b0;
        rdy1 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_decim();
        test_en_toggle();
        test_reset_mid();
        test_overflow();
        test_full_same_edge();
`ifdef OUT_SAMPLER_MINMAX_EN
        test_minmax();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
